flashing_light_seq: RTL and testbench

- Sequencing controller for the flashing_light AXI4-Lite peripheral.
- Takes the four slave-register values (control, period, pattern, step limit) and a load strobe from the AXI register file.
- Steps an LED pattern at a programmed rate in one of four modes, with continuous or counted (one-shot) runs.
- Sits between the register file and the board LED pins; reports busy/done/step index back for status readback.

---
 rtl/flashing_light_seq.sv | 174 +++++++++++++++++
 tb/tb_flashing_light_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/flashing_light_seq.sv
// LED pattern sequencer: steps a latched pattern every max(period,1) cycles in rotate/blink/ping-pong modes.
// Optional PWM dimming of the LED outputs is compiled in with `define FLASHING_LIGHT_PWM_EN.
module flashing_light_seq #(
    parameter int NUM_LEDS  = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 cfg_load,
    input  logic [31:0]          cfg_ctrl,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic [31:0]          cfg_pattern,
    input  logic [CNT_WIDTH-1:0] cfg_steps,
    output logic [NUM_LEDS-1:0]  led,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] step_idx
);

    localparam logic [NUM_LEDS-1:0]  LED_ONE = NUM_LEDS'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [1:0]           mode;
    logic [CNT_WIDTH-1:0] period_m1;
    logic [CNT_WIDTH-1:0] steps;
    logic [CNT_WIDTH-1:0] tick;
    logic [NUM_LEDS-1:0]  base_pat;
    logic [NUM_LEDS-1:0]  pat;
    logic                 dir;

    logic [NUM_LEDS-1:0]  cfg_pat_w;
    logic [NUM_LEDS-1:0]  lowest_set;
    logic [NUM_LEDS-1:0]  start_pat;
    logic [CNT_WIDTH-1:0] cfg_period_m1;
    logic [NUM_LEDS-1:0]  next_pat;
    logic                 next_dir;
    logic [CNT_WIDTH-1:0] step_next;
    logic                 step_adv;
    logic                 last_step;
    logic                 cfg_unused;

    // Only some control/pattern bits matter; fold the rest into a sink.
    assign cfg_unused = ^{cfg_ctrl, cfg_pattern};

    assign cfg_pat_w     = cfg_pattern[NUM_LEDS-1:0];
    // Two's-complement trick isolates the lowest set bit.
    assign lowest_set    = cfg_pat_w & (~cfg_pat_w + LED_ONE);
    assign cfg_period_m1 = (cfg_period == '0) ? '0 : cfg_period - CNT_ONE;

    always_comb begin
        start_pat = cfg_pat_w;
        if (cfg_ctrl[2:1] == 2'd3) begin
            start_pat = (lowest_set == '0) ? LED_ONE : lowest_set;
        end
    end

    always_comb begin
        next_pat = pat;
        next_dir = dir;
        case (mode)
            2'd0: next_pat = {pat[NUM_LEDS-2:0], pat[NUM_LEDS-1]};
            2'd1: next_pat = {pat[0], pat[NUM_LEDS-1:1]};
            2'd2: begin
                // dir doubles as the blink phase: 0 = pattern shown, 1 = dark.
                next_dir = ~dir;
                next_pat = dir ? base_pat : '0;
            end
            default: begin
                if (!dir) begin
                    if (pat[NUM_LEDS-1]) begin
                        next_dir = 1'b1;
                        next_pat = pat >> 1;
                    end else begin
                        next_pat = pat << 1;
                    end
                end else begin
                    if (pat[0]) begin
                        next_dir = 1'b0;
                        next_pat = pat << 1;
                    end else begin
                        next_pat = pat >> 1;
                    end
                end
            end
        endcase
    end

    assign step_adv  = (state == RUN) && (tick == period_m1);
    assign step_next = (step_idx == '1) ? step_idx : step_idx + CNT_ONE;
    assign last_step = (steps != '0) && (step_next == steps);

`ifdef FLASHING_LIGHT_PWM_EN
    logic [7:0] duty;
    logic [7:0] pwm_cnt;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    assign led = pat & {NUM_LEDS{pwm_cnt < duty}};
`else
    assign led = pat;
`endif

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state     <= IDLE;
            mode      <= '0;
            period_m1 <= '0;
            steps     <= '0;
            tick      <= '0;
            base_pat  <= '0;
            pat       <= '0;
            dir       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            step_idx  <= '0;
`ifdef FLASHING_LIGHT_PWM_EN
            duty      <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (cfg_load) begin
                mode      <= cfg_ctrl[2:1];
                period_m1 <= cfg_period_m1;
                steps     <= cfg_steps;
                base_pat  <= cfg_pat_w;
                tick      <= '0;
                step_idx  <= '0;
                dir       <= 1'b0;
`ifdef FLASHING_LIGHT_PWM_EN
                duty      <= cfg_ctrl[15:8];
`endif
                if (cfg_ctrl[0]) begin
                    state <= RUN;
                    busy  <= 1'b1;
                    pat   <= start_pat;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    pat   <= '0;
                end
            end else if (state == RUN) begin
                if (step_adv) begin
                    tick     <= '0;
                    step_idx <= step_next;
                    if (last_step) begin
                        // Final advance freezes the LEDs on the last shown value.
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        pat <= next_pat;
                        dir <= next_dir;
                    end
                end else begin
                    tick <= tick + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_flashing_light_seq.sv
// Directed bench for flashing_light_seq with NUM_LEDS=4; PWM checks compile in with FLASHING_LIGHT_PWM_EN.
module tb_flashing_light_seq;

    logic        ACLK;
    logic        ARESET;
    logic        cfg_load;
    logic [31:0] cfg_ctrl;
    logic [31:0] cfg_period;
    logic [31:0] cfg_pattern;
    logic [31:0] cfg_steps;
    logic [3:0]  led;
    logic        busy;
    logic        done;
    logic [31:0] step_idx;

    int n_checks = 0;
    int n_pass   = 0;

    flashing_light_seq #(.NUM_LEDS(4), .CNT_WIDTH(32)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .cfg_load    (cfg_load),
        .cfg_ctrl    (cfg_ctrl),
        .cfg_period  (cfg_period),
        .cfg_pattern (cfg_pattern),
        .cfg_steps   (cfg_steps),
        .led         (led),
        .busy        (busy),
        .done        (done),
        .step_idx    (step_idx)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Returns on the falling edge of the first cycle after the load strobe.
    task automatic load(input logic [31:0] ctrl, input logic [31:0] per,
                        input logic [31:0] pat, input logic [31:0] stp);
        @(negedge ACLK);
        cfg_ctrl    = ctrl;
        cfg_period  = per;
        cfg_pattern = pat;
        cfg_steps   = stp;
        cfg_load    = 1'b1;
        @(negedge ACLK);
        cfg_load    = 1'b0;
    endtask

    initial begin
        logic [31:0] pp  [8] = '{1, 2, 4, 8, 4, 2, 1, 2};
        logic [31:0] pp6 [6] = '{2, 4, 8, 4, 2, 1};
        logic [31:0] rr  [5] = '{8, 4, 2, 1, 8};
        ARESET = 1'b1;
        cfg_load = 1'b0;
        cfg_ctrl = '0;
        cfg_period = '0;
        cfg_pattern = '0;
        cfg_steps = '0;
        repeat (3) @(negedge ACLK);
        chk("rst_led", 32'(led), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_step", step_idx, 0);
        ARESET = 1'b0;
        repeat (3) @(negedge ACLK);
        chk("idle_led", 32'(led), 0);
        chk("idle_busy", 32'(busy), 0);

        // Rotate left, each value held 3 cycles
        load(32'h1, 3, 32'h1, 0);
        for (int i = 0; i < 15; i++) begin
            chk("m0_led", 32'(led), 32'd1 << ((i / 3) % 4));
            chk("m0_busy", 32'(busy), 1);
            chk("m0_step", step_idx, 32'(i / 3));
            if (i != 14) @(negedge ACLK);
        end

        // Asynchronous reset in the middle of a run
        #2 ARESET = 1'b1;
        #1;
        chk("arst_led", 32'(led), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_step", step_idx, 0);
        #200 ARESET = 1'b0;
        repeat (5) begin
            @(negedge ACLK);
            chk("post_rst_led", 32'(led), 0);
            chk("post_rst_busy", 32'(busy), 0);
        end

        // Ping-pong from zero pattern, period 1
        load(32'h7, 1, 32'h0, 0);
        for (int i = 0; i < 8; i++) begin
            chk("m3_led", 32'(led), pp[i]);
            @(negedge ACLK);
        end

        // Ping-pong starting at the lowest set bit of 0x6
        load(32'h7, 1, 32'h6, 0);
        for (int i = 0; i < 6; i++) begin
            chk("m3b_led", 32'(led), pp6[i]);
            @(negedge ACLK);
        end

        // One-shot blink: 4 steps of 2 cycles
        load(32'h5, 2, 32'h5, 4);
        for (int i = 0; i < 8; i++) begin
            chk("os_led", 32'(led), ((i / 2) % 2 == 0) ? 32'h5 : 32'h0);
            chk("os_busy", 32'(busy), 1);
            chk("os_done", 32'(done), 0);
            chk("os_step", step_idx, 32'(i / 2));
            @(negedge ACLK);
        end
        chk("os_done_pulse", 32'(done), 1);
        chk("os_busy_end", 32'(busy), 0);
        chk("os_led_end", 32'(led), 0);
        chk("os_step_end", step_idx, 4);
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            chk("os_done_low", 32'(done), 0);
            chk("os_hold_led", 32'(led), 0);
            chk("os_hold_step", step_idx, 4);
            chk("os_hold_busy", 32'(busy), 0);
        end

        // Reload mid-step with period 0, rotate right from 0x8
        load(32'h1, 5, 32'h1, 0);
        @(negedge ACLK);
        chk("pre_reload_led", 32'(led), 1);
        load(32'h3, 0, 32'h8, 0);
        for (int i = 0; i < 5; i++) begin
            chk("rl_led", 32'(led), rr[i]);
            chk("rl_step", step_idx, 32'(i));
            @(negedge ACLK);
        end

        // Load with enable low goes to IDLE
        load(32'h0, 1, 32'h1, 0);
        for (int i = 0; i < 3; i++) begin
            chk("dis_led", 32'(led), 0);
            chk("dis_busy", 32'(busy), 0);
            chk("dis_step", step_idx, 0);
            @(negedge ACLK);
        end

        // Zero pattern rotate: dark, steps still counted
        load(32'h3, 1, 32'h0, 0);
        for (int i = 0; i < 5; i++) begin
            chk("zp_led", 32'(led), 0);
            chk("zp_step", step_idx, 32'(i));
            chk("zp_busy", 32'(busy), 1);
            @(negedge ACLK);
        end

        // Single-step one-shot
        load(32'h1, 2, 32'h1, 1);
        chk("s1_led0", 32'(led), 1);
        @(negedge ACLK);
        chk("s1_led1", 32'(led), 1);
        chk("s1_busy1", 32'(busy), 1);
        @(negedge ACLK);
        chk("s1_done", 32'(done), 1);
        chk("s1_busy", 32'(busy), 0);
        chk("s1_led", 32'(led), 1);
        chk("s1_step", step_idx, 1);
        @(negedge ACLK);
        chk("s1_done_low", 32'(done), 0);

`ifdef FLASHING_LIGHT_PWM_EN
        begin
            int on_cnt;
            load(32'h0000_4001, 1000, 32'h1, 0);
            on_cnt = 0;
            for (int i = 0; i < 256; i++) begin
                if (led[0]) on_cnt++;
                @(negedge ACLK);
            end
            chk("pwm64_on", 32'(on_cnt), 64);
            load(32'h0000_0001, 1000, 32'h1, 0);
            on_cnt = 0;
            for (int i = 0; i < 256; i++) begin
                if (led != 4'd0) on_cnt++;
                @(negedge ACLK);
            end
            chk("pwm0_on", 32'(on_cnt), 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
